mips_instr_encoder: RTL and testbench

Program-loader encoder: accepts symbolic instruction descriptors over a valid/ready stream and produces MIPS32 instruction words. It writes them into consecutive instruction-memory locations through a handshaked write port. It is the inverse of the processor's instruction decoder and covers the same instruction set. It sits between the test/boot loader and the InstructionFetchUnit memory.

---
 rtl/mips_isa_pkg.sv | 126 ++++++++++++
 rtl/mips_instr_pack.sv | 70 +++++++
 rtl/mips_instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS32 ISA constants for the program-loader encoder and the decoder:
// symbolic op enum, major opcodes, function codes and encoder FSM states.
package mips_isa_pkg;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_SLL   = 6'd1,
    OP_ROTR  = 6'd2,
    OP_SLLV  = 6'd3,
    OP_ROTRV = 6'd4,
    OP_JR    = 6'd5,
    OP_MOVZ  = 6'd6,
    OP_ADD   = 6'd7,
    OP_ADDU  = 6'd8,
    OP_SUB   = 6'd9,
    OP_SUBU  = 6'd10,
    OP_AND   = 6'd11,
    OP_OR    = 6'd12,
    OP_XOR   = 6'd13,
    OP_NOR   = 6'd14,
    OP_SLT   = 6'd15,
    OP_SLTU  = 6'd16,
    OP_MUL   = 6'd17,
    OP_CLZ   = 6'd18,
    OP_CLO   = 6'd19,
    OP_BEQ   = 6'd20,
    OP_BNE   = 6'd21,
    OP_BGTZ  = 6'd22,
    OP_ADDI  = 6'd23,
    OP_ADDIU = 6'd24,
    OP_SLTI  = 6'd25,
    OP_SLTIU = 6'd26,
    OP_ANDI  = 6'd27,
    OP_ORI   = 6'd28,
    OP_XORI  = 6'd29,
    OP_LUI   = 6'd30,
    OP_LB    = 6'd31,
    OP_LH    = 6'd32,
    OP_LW    = 6'd33,
    OP_LBU   = 6'd34,
    OP_LHU   = 6'd35,
    OP_SW    = 6'd36,
    OP_BLTZ  = 6'd37,
    OP_BGEZ  = 6'd38,
    OP_J     = 6'd39,
    OP_JAL   = 6'd40
  } op_e;

  // Major opcodes
  localparam logic [5:0] OPC_SPECIAL  = 6'd0;
  localparam logic [5:0] OPC_REGIMM   = 6'd1;
  localparam logic [5:0] OPC_J        = 6'd2;
  localparam logic [5:0] OPC_JAL      = 6'd3;
  localparam logic [5:0] OPC_BEQ      = 6'd4;
  localparam logic [5:0] OPC_BNE      = 6'd5;
  localparam logic [5:0] OPC_BGTZ     = 6'd7;
  localparam logic [5:0] OPC_ADDI     = 6'd8;
  localparam logic [5:0] OPC_ADDIU    = 6'd9;
  localparam logic [5:0] OPC_SLTI     = 6'd10;
  localparam logic [5:0] OPC_SLTIU    = 6'd11;
  localparam logic [5:0] OPC_ANDI     = 6'd12;
  localparam logic [5:0] OPC_ORI      = 6'd13;
  localparam logic [5:0] OPC_XORI     = 6'd14;
  localparam logic [5:0] OPC_LUI      = 6'd15;
  localparam logic [5:0] OPC_SPECIAL2 = 6'd28;
  localparam logic [5:0] OPC_LB       = 6'd32;
  localparam logic [5:0] OPC_LH       = 6'd33;
  localparam logic [5:0] OPC_LW       = 6'd35;
  localparam logic [5:0] OPC_LBU      = 6'd36;
  localparam logic [5:0] OPC_LHU      = 6'd37;
  localparam logic [5:0] OPC_SW       = 6'd43;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_ROTR  = 6'd2;
  localparam logic [5:0] FN_SLLV  = 6'd4;
  localparam logic [5:0] FN_ROTRV = 6'd6;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MOVZ  = 6'd10;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  // SPECIAL2 function codes
  localparam logic [5:0] FN2_MUL = 6'd2;
  localparam logic [5:0] FN2_CLZ = 6'd32;
  localparam logic [5:0] FN2_CLO = 6'd33;

  // REGIMM selectors carried in the rt field
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] rWord(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {OPC_SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] s2Word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OPC_SPECIAL2, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] iWord(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jWord(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: symbolic op plus raw fields -> MIPS32 word and a legal flag.
// Fields an instruction does not use are forced to zero so garbage inputs never leak.
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_NOP:   word = '0;
      // Shift-immediate forms take rs from the encoding, not the descriptor
      OP_SLL:   word = rWord(5'd0, rt, rd, shamt, FN_SLL);
      OP_ROTR:  word = rWord(5'd1, rt, rd, shamt, FN_ROTR);
      OP_SLLV:  word = rWord(rs, rt, rd, 5'd0, FN_SLLV);
      OP_ROTRV: word = rWord(rs, rt, rd, 5'd1, FN_ROTRV);
      OP_JR:    word = rWord(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_MOVZ:  word = rWord(rs, rt, rd, 5'd0, FN_MOVZ);
      OP_ADD:   word = rWord(rs, rt, rd, 5'd0, FN_ADD);
      OP_ADDU:  word = rWord(rs, rt, rd, 5'd0, FN_ADDU);
      OP_SUB:   word = rWord(rs, rt, rd, 5'd0, FN_SUB);
      OP_SUBU:  word = rWord(rs, rt, rd, 5'd0, FN_SUBU);
      OP_AND:   word = rWord(rs, rt, rd, 5'd0, FN_AND);
      OP_OR:    word = rWord(rs, rt, rd, 5'd0, FN_OR);
      OP_XOR:   word = rWord(rs, rt, rd, 5'd0, FN_XOR);
      OP_NOR:   word = rWord(rs, rt, rd, 5'd0, FN_NOR);
      OP_SLT:   word = rWord(rs, rt, rd, 5'd0, FN_SLT);
      OP_SLTU:  word = rWord(rs, rt, rd, 5'd0, FN_SLTU);
      OP_MUL:   word = s2Word(rs, rt, rd, FN2_MUL);
      OP_CLZ:   word = s2Word(rs, rt, rd, FN2_CLZ);
      OP_CLO:   word = s2Word(rs, rt, rd, FN2_CLO);
      OP_BEQ:   word = iWord(OPC_BEQ, rs, rt, imm);
      OP_BNE:   word = iWord(OPC_BNE, rs, rt, imm);
      OP_BGTZ:  word = iWord(OPC_BGTZ, rs, 5'd0, imm);
      OP_ADDI:  word = iWord(OPC_ADDI, rs, rt, imm);
      OP_ADDIU: word = iWord(OPC_ADDIU, rs, rt, imm);
      OP_SLTI:  word = iWord(OPC_SLTI, rs, rt, imm);
      OP_SLTIU: word = iWord(OPC_SLTIU, rs, rt, imm);
      OP_ANDI:  word = iWord(OPC_ANDI, rs, rt, imm);
      OP_ORI:   word = iWord(OPC_ORI, rs, rt, imm);
      OP_XORI:  word = iWord(OPC_XORI, rs, rt, imm);
      OP_LUI:   word = iWord(OPC_LUI, 5'd0, rt, imm);
      OP_LB:    word = iWord(OPC_LB, rs, rt, imm);
      OP_LH:    word = iWord(OPC_LH, rs, rt, imm);
      OP_LW:    word = iWord(OPC_LW, rs, rt, imm);
      OP_LBU:   word = iWord(OPC_LBU, rs, rt, imm);
      OP_LHU:   word = iWord(OPC_LHU, rs, rt, imm);
      OP_SW:    word = iWord(OPC_SW, rs, rt, imm);
      OP_BLTZ:  word = iWord(OPC_REGIMM, rs, RT_BLTZ, imm);
      OP_BGEZ:  word = iWord(OPC_REGIMM, rs, RT_BGEZ, imm);
      OP_J:     word = jWord(OPC_J, target);
      OP_JAL:   word = jWord(OPC_JAL, target);
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program-loader encoder: accepts instruction descriptors, packs them and writes
// consecutive instruction-memory words through a valid/ready write port.
//
// state | meaning
// IDLE  | ready for a descriptor, no write outstanding
// PEND  | encoded word held on the memory port until mem_ready
// DONE  | program complete or memory full; waits for restart
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_e            state, stateNext;
  logic [ADDR_W-1:0] addrReg, addrNext;
  logic [ADDR_W:0]   countReg, countNext, countInc;
  logic [31:0]       wdataReg, wdataNext;
  logic              pendLast, pendLastNext;
  logic              errIllegal, errIllegalNext;
  logic              errFull, errFullNext;
  logic [31:0]       packWord;
  logic              packLegal;
  logic              accept;

  mips_instr_pack uPack (
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .imm    (in_imm),
    .target (in_target),
    .word   (packWord),
    .legal  (packLegal)
  );

  assign countInc = countReg + (ADDR_W+1)'(1);

  always_comb begin
    stateNext      = state;
    addrNext       = addrReg;
    countNext      = countReg;
    wdataNext      = wdataReg;
    pendLastNext   = pendLast;
    errIllegalNext = errIllegal;
    errFullNext    = errFull;
    in_ready       = 1'b0;

    case (state)
      ST_IDLE: in_ready = 1'b1;
      // Overlap the next accept with the retiring write unless it closes the program
      ST_PEND: in_ready = mem_ready & ~pendLast & (countInc < FULL_COUNT);
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (packLegal) begin
            wdataNext    = packWord;
            pendLastNext = in_last;
            stateNext    = ST_PEND;
          end else begin
            errIllegalNext = 1'b1;
            stateNext      = in_last ? ST_DONE : ST_IDLE;
          end
        end
      end
      ST_PEND: begin
        if (mem_ready) begin
          addrNext  = addrReg + ADDR_W'(1);
          countNext = countInc;
          if (pendLast) begin
            stateNext = ST_DONE;
          end else if (countInc == FULL_COUNT) begin
            stateNext   = ST_DONE;
            errFullNext = 1'b1;
          end else if (accept) begin
            if (packLegal) begin
              wdataNext    = packWord;
              pendLastNext = in_last;
              stateNext    = ST_PEND;
            end else begin
              errIllegalNext = 1'b1;
              stateNext      = in_last ? ST_DONE : ST_IDLE;
            end
          end else begin
            stateNext = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (restart) begin
          stateNext = ST_IDLE;
          addrNext  = BASE_ADDR;
          countNext = '0;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      addrReg    <= BASE_ADDR;
      countReg   <= '0;
      wdataReg   <= '0;
      pendLast   <= 1'b0;
      errIllegal <= 1'b0;
      errFull    <= 1'b0;
    end else begin
      state      <= stateNext;
      addrReg    <= addrNext;
      countReg   <= countNext;
      wdataReg   <= wdataNext;
      pendLast   <= pendLastNext;
      errIllegal <= errIllegalNext;
      errFull    <= errFullNext;
    end
  end

  // Write request comes straight from state so reset drops it asynchronously
  assign mem_we      = (state == ST_PEND);
  assign busy        = (state == ST_PEND);
  assign done        = (state == ST_DONE);
  assign mem_addr    = addrReg;
  assign mem_wdata   = wdataReg;
  assign word_count  = countReg;
  assign err_illegal = errIllegal;
  assign err_full    = errFull;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized
// programs scored against an arithmetic reference encoder and write scoreboard.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          Clk = 1'b0, Reset = 1'b0, restart = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, mem_ready = 1'b1;
  logic [5:0]    in_op = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          in_ready, mem_we, busy, done, err_illegal, err_full;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  int checks = 0, errors = 0, cyc = 0, writes = 0;
  bit readyAuto = 1'b0;
  int readyPct  = 100;
  logic [31:0] expWord[$];
  int          expAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  int mAddr = 0, mCount = 0;
  bit mErrIll = 0, mErrFull = 0, mDone = 0;
  bit ok;

  mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(3'd0)) dut (
    .Clk(Clk), .Reset(Reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err_illegal(err_illegal), .err_full(err_full), .word_count(word_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: field placement by weighted sums, codes typed from the ISA tables
  function automatic int unsigned rT(int rs, int rt, int rd, int sh, int fn);
    return rs * 32'h200000 + rt * 32'h10000 + rd * 32'h800 + sh * 64 + fn;
  endfunction
  function automatic int unsigned iT(int opc, int rs, int rt, int imm);
    return opc * 32'h4000000 + rs * 32'h200000 + rt * 32'h10000 + imm;
  endfunction

  function automatic int unsigned refEncode(int op, int rs, int rt, int rd, int sh, int imm,
                                            int tgt, output bit legal);
    legal = 1'b1;
    case (op)
      OP_NOP:   return 0;
      OP_SLL:   return rT(0, rt, rd, sh, 0);
      OP_ROTR:  return rT(1, rt, rd, sh, 2);
      OP_SLLV:  return rT(rs, rt, rd, 0, 4);
      OP_ROTRV: return rT(rs, rt, rd, 1, 6);
      OP_JR:    return rT(rs, 0, 0, 0, 8);
      OP_MOVZ:  return rT(rs, rt, rd, 0, 10);
      OP_ADD:   return rT(rs, rt, rd, 0, 32);
      OP_ADDU:  return rT(rs, rt, rd, 0, 33);
      OP_SUB:   return rT(rs, rt, rd, 0, 34);
      OP_SUBU:  return rT(rs, rt, rd, 0, 35);
      OP_AND:   return rT(rs, rt, rd, 0, 36);
      OP_OR:    return rT(rs, rt, rd, 0, 37);
      OP_XOR:   return rT(rs, rt, rd, 0, 38);
      OP_NOR:   return rT(rs, rt, rd, 0, 39);
      OP_SLT:   return rT(rs, rt, rd, 0, 42);
      OP_SLTU:  return rT(rs, rt, rd, 0, 43);
      OP_MUL:   return 28 * 32'h4000000 + rT(rs, rt, rd, 0, 2);
      OP_CLZ:   return 28 * 32'h4000000 + rT(rs, rt, rd, 0, 32);
      OP_CLO:   return 28 * 32'h4000000 + rT(rs, rt, rd, 0, 33);
      OP_BEQ:   return iT(4, rs, rt, imm);
      OP_BNE:   return iT(5, rs, rt, imm);
      OP_BGTZ:  return iT(7, rs, 0, imm);
      OP_ADDI:  return iT(8, rs, rt, imm);
      OP_ADDIU: return iT(9, rs, rt, imm);
      OP_SLTI:  return iT(10, rs, rt, imm);
      OP_SLTIU: return iT(11, rs, rt, imm);
      OP_ANDI:  return iT(12, rs, rt, imm);
      OP_ORI:   return iT(13, rs, rt, imm);
      OP_XORI:  return iT(14, rs, rt, imm);
      OP_LUI:   return iT(15, 0, rt, imm);
      OP_LB:    return iT(32, rs, rt, imm);
      OP_LH:    return iT(33, rs, rt, imm);
      OP_LW:    return iT(35, rs, rt, imm);
      OP_LBU:   return iT(36, rs, rt, imm);
      OP_LHU:   return iT(37, rs, rt, imm);
      OP_SW:    return iT(43, rs, rt, imm);
      OP_BLTZ:  return iT(1, rs, 0, imm);
      OP_BGEZ:  return iT(1, rs, 1, imm);
      OP_J:     return 2 * 32'h4000000 + tgt;
      OP_JAL:   return 3 * 32'h4000000 + tgt;
      default: begin
        legal = 1'b0;
        return 0;
      end
    endcase
  endfunction

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial forever begin
    @(posedge Clk);
    #1;
    if (readyAuto) mem_ready = ($urandom_range(0, 99) < readyPct);
  end

  // Write monitor: every accepted memory write is scored in order
  initial forever begin
    @(negedge Clk);
    if (Reset && mem_we && mem_ready) begin
      writes++;
      wrCyc.push_back(cyc);
      wrData.push_back(mem_wdata);
      if (expWord.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("wr_addr", 32'(mem_addr), expAddr.pop_front());
        chk("wr_data", mem_wdata, expWord.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input bit last, output bit acc);
    bit lg;
    int unsigned w;
    in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge Clk);
      if (in_ready) begin
        w = refEncode(op, rs, rt, rd, sh, imm, tgt, lg);
        if (lg) begin
          expWord.push_back(w);
          expAddr.push_back(mAddr);
          mAddr = (mAddr + 1) % DEPTH;
          mCount++;
          if (last) mDone = 1;
          else if (mCount == DEPTH) begin
            mDone = 1;
            mErrFull = 1;
          end
        end else begin
          mErrIll = 1;
          if (last) mDone = 1;
        end
        acc = 1'b1;
      end
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((expWord.size() != 0 || mem_we) && n < 300) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (n >= 300) chk({tag, "_drain_timeout"}, 0, 1);
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b0; in_valid = 1'b0; restart = 1'b0;
    expWord.delete(); expAddr.delete(); wrData.delete(); wrCyc.delete();
    mAddr = 0; mCount = 0; mErrIll = 0; mErrFull = 0; mDone = 0; writes = 0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    @(posedge Clk); #1;
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_full", err_full, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;

    // Single ADD, then a restart outside DONE must be ignored
    mem_ready = 1'b1;
    send(OP_ADD, 1, 2, 3, 0, 0, 0, 0, ok);
    chk("add_accept", ok, 1);
    @(negedge Clk);
    chk("add_we", mem_we, 1);
    chk("add_word", mem_wdata, 32'h00221820);
    chk("add_addr", mem_addr, 0);
    @(posedge Clk); #1;
    pulseRestart();
    @(negedge Clk);
    chk("restart_ignored_count", word_count, 1);
    chk("restart_ignored_addr", mem_addr, 1);
    @(posedge Clk); #1;

    // Back-to-back program ending in a jump
    doReset();
    send(OP_ADDI, 0, 8, 0, 0, 5, 0, 0, ok);
    send(OP_LW, 29, 9, 0, 0, 4, 0, 0, ok);
    send(OP_J, 0, 0, 0, 0, 0, 32'h10, 1, ok);
    drain("b2b");
    chk("b2b_writes", writes, 3);
    if (writes == 3) begin
      chk("b2b_w0", wrData[0], 32'h20080005);
      chk("b2b_w1", wrData[1], 32'h8FA90004);
      chk("b2b_w2", wrData[2], 32'h08000010);
      chk("b2b_gap01", wrCyc[1] - wrCyc[0], 1);
      chk("b2b_gap12", wrCyc[2] - wrCyc[1], 1);
    end
    chk("b2b_done", done, 1);
    chk("b2b_count", word_count, 3);
    chk("b2b_in_ready", in_ready, 0);

    // Back-pressure: SLL held while memory stalls, rs garbage dropped
    doReset();
    mem_ready = 1'b0;
    send(OP_SLL, 31, 1, 2, 4, 16'h1234, 0, 0, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("stall_we", mem_we, 1);
      chk("stall_word", mem_wdata, 32'h00011100);
      chk("stall_in_ready", in_ready, 0);
      @(posedge Clk); #1;
    end
    mem_ready = 1'b1;
    drain("stall");
    chk("stall_writes", writes, 1);

    // Legal REGIMM branch followed by an illegal op
    doReset();
    send(OP_BGEZ, 4, 7, 9, 3, 16'hFFFE, 0, 0, ok);
    send(63, 1, 2, 3, 4, 5, 6, 0, ok);
    chk("ill_accept", ok, 1);
    drain("ill");
    chk("ill_writes", writes, 1);
    if (writes == 1) chk("bgez_word", wrData[0], 32'h0481FFFE);
    chk("ill_flag", err_illegal, 1);
    chk("ill_count", word_count, 1);
    chk("ill_done", done, 0);
    chk("ill_in_ready", in_ready, 1);

    // Fill memory without a last descriptor
    doReset();
    readyAuto = 1'b1; readyPct = 60;
    for (int i = 0; i < DEPTH; i++) begin
      send($urandom_range(0, 40), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
           $urandom_range(0, 32'h3FFFFFF), 0, ok);
      if (!ok) chk("full_accept", 0, 1);
    end
    drain("full");
    chk("full_done", done, 1);
    chk("full_flag", err_full, 1);
    chk("full_count", word_count, DEPTH);
    chk("full_writes", writes, DEPTH);
    chk("full_addr_wrap", mem_addr, 32'(mAddr));
    in_op = 6'(OP_ADD); in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("full_in_ready", in_ready, 0);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    chk("full_no_extra", writes, DEPTH);
    pulseRestart();
    mAddr = 0; mCount = 0; mDone = 0;
    @(negedge Clk);
    chk("restart_count", word_count, 0);
    chk("restart_addr", mem_addr, 0);
    chk("restart_done", done, 0);
    chk("restart_in_ready", in_ready, 1);
    chk("restart_err_full_sticky", err_full, 1);
    @(posedge Clk); #1;

    // Randomized programs with occasional illegal ops
    readyPct = 75;
    for (int p = 0; p < 12; p++) begin
      int len;
      len = $urandom_range(1, DEPTH - 1);
      for (int k = 0; k < len; k++) begin
        int op;
        op = ($urandom_range(0, 99) < 15) ? $urandom_range(41, 63) : $urandom_range(0, 40);
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF),
             k == len - 1, ok);
        if (!ok) chk("rand_accept", 0, 1);
      end
      drain("rand");
      chk("rand_done", done, 32'(mDone));
      chk("rand_count", word_count, mCount);
      chk("rand_addr", mem_addr, 32'(mAddr));
      chk("rand_err_illegal", err_illegal, 32'(mErrIll));
      pulseRestart();
      mAddr = 0; mCount = 0; mDone = 0;
    end

    // Asynchronous reset while a write is pending
    readyAuto = 1'b0;
    mem_ready = 1'b0;
    send(OP_OR, 5, 6, 7, 0, 0, 0, 0, ok);
    @(negedge Clk);
    chk("arst_pend_we", mem_we, 1);
    #2;
    Reset = 1'b0;
    expWord.delete(); expAddr.delete();
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_word_count", word_count, 0);
    chk("arst_done", done, 0);
    chk("arst_err_illegal", err_illegal, 0);
    chk("arst_err_full", err_full, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge Clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
